cache_array: RTL and testbench



---
 rtl/cache_array_if.sv | 31 +++
 rtl/cache_array.sv | 150 +++++++++++++++
 tb/tb_cache_array.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_array_if.sv
// Request/response bundle between the cache controller and one cache_array way.
// The master modport is the controller side; the slave modport is the array side.
interface cache_array_if #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DEPTH-1:0]  wl;
  logic [TAG_W-1:0]  tag_in;
  logic [DATA_W-1:0] data_in;
  logic              resp_valid;
  logic [TAG_W-1:0]  tag_out;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              hit;
  logic              err;
  logic              par_err;

  modport master (
    output req_valid, req_op, wl, tag_in, data_in,
    input  req_ready, resp_valid, tag_out, data_out, valid_out, hit, err, par_err
  );

  modport slave (
    input  req_valid, req_op, wl, tag_in, data_in,
    output req_ready, resp_valid, tag_out, data_out, valid_out, hit, err, par_err
  );
endinterface

// File: rtl/cache_array.sv
// Tag/data storage way: one-hot wordline access, registered read, tag lookup, flash-invalidate.
// Optional even parity per entry is enabled with `define CACHE_ARRAY_PARITY_EN.
module cache_array #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_array_if.slave bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_LOOKUP = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   flush_cnt_reg;
  logic [DEPTH-1:0]    valid_reg;
  logic                resp_valid_reg;
  logic                show_reg;
  logic                valid_out_reg;
  logic                hit_cand_reg;
  logic                par_chk_reg;
  logic                err_reg;

  logic [TAG_W-1:0]    tag_mem  [DEPTH];
  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic [TAG_W-1:0]    rd_tag_reg;
  logic [DATA_W-1:0]   rd_data_reg;
  logic [TAG_W-1:0]    cmp_tag_reg;

  logic [ADDR_W-1:0]   idx;
  logic                wl_err;
  logic                accept;
  logic                wr_en;
  logic                rd_en;
  logic                par_err;

  // Encode by OR-ing indices of set bits; only meaningful when wl is one-hot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.wl[i]) idx = idx | ADDR_W'(i);
    end
  end

  assign wl_err = (bus.wl == '0) || ((bus.wl & (bus.wl - DEPTH'(1))) != '0);
  assign accept = bus.req_valid && (state_reg == IDLE);
  assign wr_en  = accept && (bus.req_op == OP_WRITE) && !wl_err;
  assign rd_en  = accept && ((bus.req_op == OP_READ) || (bus.req_op == OP_LOOKUP)) && !wl_err;

  // Storage is not reset: only the valid bits carry reset state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[idx]  <= bus.tag_in;
      data_mem[idx] <= bus.data_in;
    end
    if (rd_en) begin
      rd_tag_reg  <= tag_mem[idx];
      rd_data_reg <= data_mem[idx];
      cmp_tag_reg <= bus.tag_in;
    end
  end

`ifdef CACHE_ARRAY_PARITY_EN
  logic par_mem [DEPTH];
  logic rd_par_reg;

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[idx] <= ^{bus.tag_in, bus.data_in};
    if (rd_en) rd_par_reg   <= par_mem[idx];
  end

  assign par_err = par_chk_reg && ((^{rd_tag_reg, rd_data_reg}) != rd_par_reg);
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      flush_cnt_reg  <= '0;
      valid_reg      <= '0;
      resp_valid_reg <= 1'b0;
      show_reg       <= 1'b0;
      valid_out_reg  <= 1'b0;
      hit_cand_reg   <= 1'b0;
      par_chk_reg    <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (bus.req_op == OP_FLUSH) begin
              state_reg     <= FLUSH;
              flush_cnt_reg <= '0;
            end else begin
              resp_valid_reg <= 1'b1;
              err_reg        <= wl_err;
              if (bus.req_op == OP_WRITE) begin
                if (!wl_err) valid_reg[idx] <= 1'b1;
                valid_out_reg <= !wl_err;
                show_reg      <= 1'b0;
                hit_cand_reg  <= 1'b0;
                par_chk_reg   <= 1'b0;
              end else begin
                // Invalid entries report zeros and skip the parity check.
                valid_out_reg <= !wl_err && valid_reg[idx];
                show_reg      <= !wl_err && valid_reg[idx];
                par_chk_reg   <= !wl_err && valid_reg[idx];
                hit_cand_reg  <= (bus.req_op == OP_LOOKUP) && !wl_err && valid_reg[idx];
              end
            end
          end
        end
        FLUSH: begin
          valid_reg[flush_cnt_reg] <= 1'b0;
          if (flush_cnt_reg == ADDR_W'(DEPTH - 1)) begin
            state_reg      <= IDLE;
            flush_cnt_reg  <= '0;
            resp_valid_reg <= 1'b1;
            err_reg        <= 1'b0;
            valid_out_reg  <= 1'b0;
            show_reg       <= 1'b0;
            hit_cand_reg   <= 1'b0;
            par_chk_reg    <= 1'b0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + ADDR_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.resp_valid = resp_valid_reg;
  assign bus.tag_out    = show_reg ? rd_tag_reg : '0;
  assign bus.data_out   = show_reg ? rd_data_reg : '0;
  assign bus.valid_out  = valid_out_reg;
  assign bus.hit        = hit_cand_reg && (rd_tag_reg == cmp_tag_reg) && !par_err;
  assign bus.err        = err_reg;
  assign bus.par_err    = par_err;
endmodule

// File: tb/tb_cache_array.sv
// Directed bench for cache_array: a reference model pushes expected responses to a
// queue at drive time; a monitor pops and compares on every resp_valid.
module tb_cache_array;
  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_LOOKUP = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              v;
    logic              hit;
    logic              err;
    logic              par;
  } exp_t;

  logic clk;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   resp_num  = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [TAG_W-1:0]  m_tag  [DEPTH];
  logic [DATA_W-1:0] m_data [DEPTH];
  logic              m_valid[DEPTH];
  logic              m_bad  [DEPTH];

  cache_array_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cache_array #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h, want %0h", name, obs, exp);
  endfunction

  // Response monitor, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.resp_valid) begin
      resp_num++;
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("resp %0d: tag=%h data=%h v=%b hit=%b err=%b par=%b", resp_num,
                 bus.tag_out, bus.data_out, bus.valid_out, bus.hit, bus.err, bus.par_err);
        check("tag_out",   32'(bus.tag_out),   32'(mon_e.tag));
        check("data_out",  32'(bus.data_out),  32'(mon_e.data));
        check("valid_out", 32'(bus.valid_out), 32'(mon_e.v));
        check("hit",       32'(bus.hit),       32'(mon_e.hit));
        check("err",       32'(bus.err),       32'(mon_e.err));
        check("par_err",   32'(bus.par_err),   32'(mon_e.par));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [DEPTH-1:0] wl,
                      input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    exp_t e;
    int   i;
    bit   bad;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.wl        = wl;
    bus.tag_in    = tag;
    bus.data_in   = data;
    bad = ($countones(wl) != 1);
    i = 0;
    for (int k = 0; k < DEPTH; k++) if (wl[k]) i = k;
    e = '{tag: '0, data: '0, v: 1'b0, hit: 1'b0, err: bad, par: 1'b0};
    if (!bad) begin
      if (op == OP_WRITE) begin
        m_tag[i] = tag; m_data[i] = data; m_valid[i] = 1'b1; m_bad[i] = 1'b0;
        e.v = 1'b1;
      end else if (m_valid[i]) begin
        e.v    = 1'b1;
        e.tag  = m_tag[i];
        e.data = m_data[i];
        e.par  = m_bad[i];
        e.hit  = (op == OP_LOOKUP) && (m_tag[i] == tag) && !m_bad[i];
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // rst_at < 0: complete flush; otherwise rst_n pulses at that flush cycle.
  task automatic do_flush(input int rst_at);
    int low_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_FLUSH;
    bus.wl        = '0;
    if (rst_at < 0) sb.push_back('{tag: '0, data: '0, v: 1'b0, hit: 1'b0, err: 1'b0, par: 1'b0});
    @(negedge clk);
    bus.req_valid = 1'b0;
    low_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.req_ready) break;
      low_cnt++;
      if (low_cnt == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_ready",      32'(bus.req_ready),  32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (rst_at < 0) check("flush_ready_low", 32'(low_cnt), 32'd16);
    for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      m_tag[k] = '0; m_data[k] = '0; m_valid[k] = 1'b0; m_bad[k] = 1'b0;
    end
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_READ;
    bus.wl        = '0;
    bus.tag_in    = '0;
    bus.data_in   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_ready",      32'(bus.req_ready),  32'd1);
    check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset_tag_out",    32'(bus.tag_out),    32'd0);
    check("reset_data_out",   32'(bus.data_out),   32'd0);
    check("reset_valid_out",  32'(bus.valid_out),  32'd0);
    check("reset_hit",        32'(bus.hit),        32'd0);
    check("reset_err",        32'(bus.err),        32'd0);
    check("reset_par_err",    32'(bus.par_err),    32'd0);

    send(OP_READ, 16'h0001, 4'h0, 8'h00);
    idle();
    send(OP_WRITE,  16'h0020, 4'hA, 8'h5C);
    send(OP_READ,   16'h0020, 4'h0, 8'h00);
    send(OP_LOOKUP, 16'h0020, 4'hA, 8'h00);
    send(OP_LOOKUP, 16'h0020, 4'hB, 8'h00);
    send(OP_WRITE,  16'h0030, 4'h3, 8'h77);
    send(OP_WRITE,  16'h0000, 4'h4, 8'h88);
    send(OP_READ,   16'h0010, 4'h0, 8'h00);
    send(OP_READ,   16'h0020, 4'h0, 8'h00);

    for (int n = 0; n < 40; n++) begin
      logic [DEPTH-1:0] w;
      w = DEPTH'(1) << $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 9) == 0) w = DEPTH'($urandom);
      send(2'($urandom_range(0, 2)), w, TAG_W'($urandom), DATA_W'($urandom));
    end
    idle();

    for (int k = 0; k < DEPTH; k++) send(OP_WRITE, DEPTH'(1) << k, TAG_W'(k), DATA_W'(k * 17 + 3));
    idle();
    do_flush(-1);
    for (int k = 0; k < DEPTH; k++) send(OP_LOOKUP, DEPTH'(1) << k, TAG_W'(k), 8'h00);
    idle();

    for (int k = 0; k < DEPTH; k++) send(OP_WRITE, DEPTH'(1) << k, TAG_W'(k + 1), DATA_W'(k * 5));
    idle();
    repeat (2) @(negedge clk);
    do_flush(7);
    for (int k = 0; k < DEPTH; k++) send(OP_LOOKUP, DEPTH'(1) << k, TAG_W'(k + 1), 8'h00);
    idle();

`ifdef CACHE_ARRAY_PARITY_EN
    send(OP_WRITE, 16'h0008, 4'h5, 8'h33);
    idle();
    @(negedge clk);
    dut.data_mem[3][0] = ~dut.data_mem[3][0];
    m_data[3][0] = ~m_data[3][0];
    m_bad[3] = 1'b1;
    send(OP_LOOKUP, 16'h0008, 4'h5, 8'h00);
    send(OP_WRITE,  16'h0008, 4'h5, 8'h33);
    send(OP_LOOKUP, 16'h0008, 4'h5, 8'h00);
    idle();
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
